// File: rtl/rv_iopmp_pkg.sv
// Shared types for the IOPMP request front end.
//  - access_t   : access type handed to the matcher
//  - burst_t    : AXI burst encoding
//  - req_desc_t : latched request descriptor
//  - state_t    : front-end FSM state
package rv_iopmp_pkg;

    localparam int unsigned IOPMP_ADDR_W = 64;
    localparam int unsigned IOPMP_DATA_W = 64;
    localparam int unsigned IOPMP_SID_W  = 8;

    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2
    } access_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_t;

    typedef struct packed {
        logic [IOPMP_ADDR_W-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        burst_t                  burst;
        logic [IOPMP_SID_W-1:0]  sid;
        logic                    is_write;
    } req_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        logic ok;
        case (len)
            8'd1, 8'd3, 8'd7, 8'd15: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv_iopmp_burst_calc.sv
// Combinational burst geometry for one request descriptor.
// Ports:
//  desc_i         : latched request descriptor
//  addr_o         : address to check (aligned down to the wrap boundary for WRAP)
//  total_length_o : bytes covered by the burst
//  num_bytes_o    : bytes per beat
//  malformed_o    : request cannot be checked and must be denied locally
module rv_iopmp_burst_calc
    import rv_iopmp_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = IOPMP_DATA_W,
    localparam int unsigned NB_W       = $clog2(DATA_WIDTH/8) + 1
) (
    input  req_desc_t               desc_i,
    output logic [IOPMP_ADDR_W-1:0] addr_o,
    output logic [IOPMP_ADDR_W-1:0] total_length_o,
    output logic [NB_W-1:0]         num_bytes_o,
    output logic                    malformed_o
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH/8));

    logic [IOPMP_ADDR_W-1:0] beats_s;
    logic                    incr_ovf_s;

    // Beat size, burst length, wrap alignment and malformed detection.
    always_comb begin
        num_bytes_o    = NB_W'(1) << desc_i.size;
        beats_s        = IOPMP_ADDR_W'(desc_i.len) + IOPMP_ADDR_W'(1);
        total_length_o = IOPMP_ADDR_W'(1) << desc_i.size;
        addr_o         = desc_i.addr;
        case (desc_i.burst)
            BURST_FIXED: total_length_o = IOPMP_ADDR_W'(1) << desc_i.size;
            BURST_INCR:  total_length_o = beats_s << desc_i.size;
            BURST_WRAP:  total_length_o = beats_s << desc_i.size;
            default:     total_length_o = IOPMP_ADDR_W'(1) << desc_i.size;
        endcase
        if (desc_i.burst == BURST_WRAP) begin
            addr_o = desc_i.addr & ~(total_length_o - IOPMP_ADDR_W'(1));
        end else begin
            addr_o = desc_i.addr;
        end
        // total_length is never zero, so addr+len-1 overflows exactly when addr > 2^W - len.
        incr_ovf_s  = (desc_i.burst == BURST_INCR) &&
                      (desc_i.addr > (IOPMP_ADDR_W'(0) - total_length_o));
        malformed_o = (desc_i.size > MAX_SIZE) ||
                      (desc_i.burst == BURST_RSVD) ||
                      ((desc_i.burst == BURST_WRAP) && !wrap_len_ok(desc_i.len)) ||
                      incr_ovf_s;
    end

endmodule

// File: rtl/rv_iopmp_req_frontend.sv
// IOPMP request front end: round-robin AR/AW arbitration, burst geometry,
// single-outstanding issue to the matcher and decision return.
// Ports:
//  clk_i, rst_ni              : clock, async active-low reset
//  ar_* / aw_*                : AXI-style read / write request descriptors
//  transaction_en_o, addr_o, total_length_o, num_bytes_o, sid_o, access_type_o,
//  ml_ready_i, ml_valid_i, ml_allow_i : matcher interface
//  stall_i                    : freezes the whole front end
//  rsp_*                      : decision returned to the originating channel
module rv_iopmp_req_frontend
    import rv_iopmp_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = IOPMP_ADDR_W,
    parameter  int unsigned DATA_WIDTH = IOPMP_DATA_W,
    parameter  int unsigned SID_WIDTH  = IOPMP_SID_W,
    localparam int unsigned NB_W       = $clog2(DATA_WIDTH/8) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]            ar_len_i,
    input  logic [2:0]            ar_size_i,
    input  logic [1:0]            ar_burst_i,
    input  logic [SID_WIDTH-1:0]  ar_sid_i,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]            aw_len_i,
    input  logic [2:0]            aw_size_i,
    input  logic [1:0]            aw_burst_i,
    input  logic [SID_WIDTH-1:0]  aw_sid_i,
    output logic                  transaction_en_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [ADDR_WIDTH-1:0] total_length_o,
    output logic [NB_W-1:0]       num_bytes_o,
    output logic [SID_WIDTH-1:0]  sid_o,
    output access_t               access_type_o,
    input  logic                  ml_ready_i,
    input  logic                  ml_valid_i,
    input  logic                  ml_allow_i,
    input  logic                  stall_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_allow_o,
    output logic                  rsp_is_write_o,
    output logic                  rsp_local_o
);

    state_t                  state_q;
    req_desc_t               desc_q;
    logic                    prefer_aw_q;
    logic                    txn_en_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   total_q;
    logic [NB_W-1:0]         nb_q;
    logic [SID_WIDTH-1:0]    sid_q;
    access_t                 access_q;
    logic                    rsp_valid_q;
    logic                    rsp_allow_q;
    logic                    rsp_is_write_q;
    logic                    rsp_local_q;

    logic                    grant_aw_s;
    logic                    accept_s;
    req_desc_t               sel_desc_s;
    logic [ADDR_WIDTH-1:0]   calc_addr_s;
    logic [ADDR_WIDTH-1:0]   calc_total_s;
    logic [NB_W-1:0]         calc_nb_s;
    logic                    calc_malformed_s;

    rv_iopmp_burst_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_burst_calc (
        .desc_i         (desc_q),
        .addr_o         (calc_addr_s),
        .total_length_o (calc_total_s),
        .num_bytes_o    (calc_nb_s),
        .malformed_o    (calc_malformed_s)
    );

    // Round-robin grant and selection of the winning descriptor.
    always_comb begin
        // AW wins when it is alone, or when both are valid and AR was served last.
        grant_aw_s = aw_valid_i && (!ar_valid_i || prefer_aw_q);
        accept_s   = (state_q == ST_IDLE) && !stall_i;
        ar_ready_o = accept_s && ar_valid_i && !grant_aw_s;
        aw_ready_o = accept_s && grant_aw_s;
        if (grant_aw_s) begin
            sel_desc_s = '{addr: aw_addr_i, len: aw_len_i, size: aw_size_i,
                           burst: burst_t'(aw_burst_i), sid: aw_sid_i, is_write: 1'b1};
        end else begin
            sel_desc_s = '{addr: ar_addr_i, len: ar_len_i, size: ar_size_i,
                           burst: burst_t'(ar_burst_i), sid: ar_sid_i, is_write: 1'b0};
        end
    end

    // Front-end FSM with all outputs registered; stall freezes every register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            desc_q         <= '0;
            prefer_aw_q    <= 1'b0;
            txn_en_q       <= 1'b0;
            addr_q         <= '0;
            total_q        <= '0;
            nb_q           <= '0;
            sid_q          <= '0;
            access_q       <= ACCESS_NONE;
            rsp_valid_q    <= 1'b0;
            rsp_allow_q    <= 1'b0;
            rsp_is_write_q <= 1'b0;
            rsp_local_q    <= 1'b0;
        end else if (stall_i) begin
            state_q <= state_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ar_ready_o || aw_ready_o) begin
                        desc_q  <= sel_desc_s;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (calc_malformed_s) begin
                        // Deny locally; the matcher never sees this request.
                        rsp_valid_q    <= 1'b1;
                        rsp_allow_q    <= 1'b0;
                        rsp_local_q    <= 1'b1;
                        rsp_is_write_q <= desc_q.is_write;
                        state_q        <= ST_RESP;
                    end else begin
                        addr_q   <= calc_addr_s;
                        total_q  <= calc_total_s;
                        nb_q     <= calc_nb_s;
                        sid_q    <= desc_q.sid;
                        access_q <= desc_q.is_write ? ACCESS_WRITE : ACCESS_READ;
                        txn_en_q <= 1'b1;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ml_ready_i) begin
                        txn_en_q <= 1'b0;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ml_valid_i) begin
                        rsp_valid_q    <= 1'b1;
                        rsp_allow_q    <= ml_allow_i;
                        rsp_local_q    <= 1'b0;
                        rsp_is_write_q <= desc_q.is_write;
                        state_q        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q    <= 1'b0;
                        rsp_allow_q    <= 1'b0;
                        rsp_local_q    <= 1'b0;
                        rsp_is_write_q <= 1'b0;
                        prefer_aw_q    <= !desc_q.is_write;
                        state_q        <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign transaction_en_o = txn_en_q;
    assign addr_o           = addr_q;
    assign total_length_o   = total_q;
    assign num_bytes_o      = nb_q;
    assign sid_o            = sid_q;
    assign access_type_o    = access_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_allow_o      = rsp_allow_q;
    assign rsp_is_write_o   = rsp_is_write_q;
    assign rsp_local_o      = rsp_local_q;

endmodule

// File: tb/tb_rv_iopmp_req_frontend.sv
// Self-checking bench for rv_iopmp_req_frontend: directed scenarios plus
// randomized traffic checked against a behavioural model of the burst rules
// and the round-robin arbitration.
module tb_rv_iopmp_req_frontend;
    import rv_iopmp_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ar_valid_i, aw_valid_i, ar_ready_o, aw_ready_o;
    logic [63:0] ar_addr_i, aw_addr_i;
    logic [7:0]  ar_len_i, aw_len_i;
    logic [2:0]  ar_size_i, aw_size_i;
    logic [1:0]  ar_burst_i, aw_burst_i;
    logic [7:0]  ar_sid_i, aw_sid_i;
    logic        transaction_en_o;
    logic [63:0] addr_o, total_length_o;
    logic [3:0]  num_bytes_o;
    logic [7:0]  sid_o;
    access_t     access_type_o;
    logic        ml_ready_i, ml_valid_i, ml_allow_i, stall_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_allow_o, rsp_is_write_o, rsp_local_o;

    int n_pass  = 0;
    int n_total = 0;
    // Model of the arbiter history: after reset AR is preferred, i.e. "AW served last".
    bit model_last_wr = 1'b1;

    typedef struct {
        logic [63:0] addr;
        int          len;
        int          size;
        int          burst;
        logic [7:0]  sid;
    } tdesc_t;

    always #5 clk_i = ~clk_i;

    rv_iopmp_req_frontend dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i), .ar_sid_i(ar_sid_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
        .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i), .aw_sid_i(aw_sid_i),
        .transaction_en_o(transaction_en_o), .addr_o(addr_o), .total_length_o(total_length_o),
        .num_bytes_o(num_bytes_o), .sid_o(sid_o), .access_type_o(access_type_o),
        .ml_ready_i(ml_ready_i), .ml_valid_i(ml_valid_i), .ml_allow_i(ml_allow_i),
        .stall_i(stall_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_allow_o(rsp_allow_o), .rsp_is_write_o(rsp_is_write_o), .rsp_local_o(rsp_local_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic tdesc_t mk(input logic [63:0] a, input int len, input int size,
                                  input int burst, input logic [7:0] sid);
        tdesc_t d;
        d.addr = a; d.len = len; d.size = size; d.burst = burst; d.sid = sid;
        return d;
    endfunction

    // Burst rules computed with plain arithmetic on a 65-bit range.
    function automatic void ref_calc(input tdesc_t d, output logic [63:0] ea,
                                     output logic [63:0] etot, output int enb, output bit mal);
        logic [64:0] last_byte;
        enb  = 1 << d.size;
        etot = (d.burst == 0) ? 64'(enb) : 64'(d.len + 1) * 64'(enb);
        ea   = (d.burst == 2) ? d.addr - (d.addr % etot) : d.addr;
        mal  = (d.size > 3) || (d.burst == 3) ||
               ((d.burst == 2) && !(d.len inside {1, 3, 7, 15}));
        last_byte = {1'b0, d.addr} + {1'b0, etot} - 65'd1;
        if (d.burst == 1 && last_byte > 65'h0_FFFF_FFFF_FFFF_FFFF) mal = 1'b1;
    endfunction

    // Drives one complete request from offer to response handshake and checks each phase.
    task automatic run_txn(input bit ar_v, input bit aw_v, input tdesc_t ard, input tdesc_t awd,
                           input bit allow, input int stall_cyc, input int rsp_hold,
                           input int ml_delay, input bit stray);
        bit win_wr, mal, exp_allow, exp_local;
        tdesc_t d;
        logic [63:0] ea, et;
        int enb;
        access_t exp_acc;
        win_wr = (ar_v && aw_v) ? !model_last_wr : aw_v;
        d = win_wr ? awd : ard;
        ref_calc(d, ea, et, enb, mal);
        exp_acc = win_wr ? ACCESS_WRITE : ACCESS_READ;

        ar_valid_i = ar_v; ar_addr_i = ard.addr; ar_len_i = 8'(ard.len);
        ar_size_i = 3'(ard.size); ar_burst_i = 2'(ard.burst); ar_sid_i = ard.sid;
        aw_valid_i = aw_v; aw_addr_i = awd.addr; aw_len_i = 8'(awd.len);
        aw_size_i = 3'(awd.size); aw_burst_i = 2'(awd.burst); aw_sid_i = awd.sid;
        #1;
        n_total++;
        if ({ar_ready_o, aw_ready_o} !== {!win_wr, win_wr})
            $display("FAIL grant: ar/aw_ready=%b%b required %b%b", ar_ready_o, aw_ready_o, !win_wr, win_wr);
        else n_pass++;
        step();                                  // cycle 1: CALC
        ar_valid_i = 1'b0; aw_valid_i = 1'b0;
        ml_valid_i = stray; ml_allow_i = !allow; // a decision outside WAIT must be ignored
        step();                                  // cycle 2
        ml_valid_i = 1'b0; ml_allow_i = 1'b0;
        if (mal) begin
            exp_allow = 1'b0; exp_local = 1'b1;
            n_total++;
            if ({rsp_valid_o, transaction_en_o} !== 2'b10)
                $display("FAIL local_deny_timing: rsp_valid/txn_en=%b%b required 10", rsp_valid_o, transaction_en_o);
            else n_pass++;
        end else begin
            exp_allow = allow; exp_local = 1'b0;
            n_total++;
            if ({transaction_en_o, addr_o, total_length_o, num_bytes_o, sid_o} !==
                {1'b1, ea, et, 4'(enb), d.sid} || access_type_o !== exp_acc)
                $display("FAIL issue: en=%b addr=%h len=%0d nb=%0d sid=%h acc=%0d required en=1 addr=%h len=%0d nb=%0d sid=%h acc=%0d",
                         transaction_en_o, addr_o, total_length_o, num_bytes_o, sid_o, access_type_o,
                         ea, et, enb, d.sid, exp_acc);
            else n_pass++;
            if (stall_cyc > 0) begin
                stall_i = 1'b1;
                repeat (stall_cyc) step();
                n_total++;
                if (transaction_en_o !== 1'b1)
                    $display("FAIL stall_issue: txn_en=%b required 1", transaction_en_o);
                else n_pass++;
                stall_i = 1'b0;
            end
            step();                              // handshake completed -> WAIT
            n_total++;
            if (transaction_en_o !== 1'b0)
                $display("FAIL handshake: txn_en=%b required 0", transaction_en_o);
            else n_pass++;
            repeat (ml_delay) step();
            n_total++;
            if (rsp_valid_o !== 1'b0)
                $display("FAIL early_rsp: rsp_valid=%b required 0", rsp_valid_o);
            else n_pass++;
            ml_valid_i = 1'b1; ml_allow_i = allow;
            step();
            ml_valid_i = 1'b0; ml_allow_i = 1'b0;
        end
        n_total++;
        if ({rsp_valid_o, rsp_allow_o, rsp_local_o, rsp_is_write_o} !== {1'b1, exp_allow, exp_local, win_wr})
            $display("FAIL response: v/allow/local/wr=%b%b%b%b required 1%b%b%b",
                     rsp_valid_o, rsp_allow_o, rsp_local_o, rsp_is_write_o, exp_allow, exp_local, win_wr);
        else n_pass++;
        for (int i = 0; i < rsp_hold; i++) begin
            ar_valid_i = 1'b1; aw_valid_i = 1'b1;
            #1;
            n_total++;
            if ({rsp_valid_o, rsp_allow_o, rsp_local_o, rsp_is_write_o, ar_ready_o, aw_ready_o} !==
                {1'b1, exp_allow, exp_local, win_wr, 2'b00})
                $display("FAIL rsp_hold: v/allow/local/wr/rdy=%b%b%b%b%b%b required 1%b%b%b00",
                         rsp_valid_o, rsp_allow_o, rsp_local_o, rsp_is_write_o, ar_ready_o, aw_ready_o,
                         exp_allow, exp_local, win_wr);
            else n_pass++;
            step();
        end
        ar_valid_i = 1'b0; aw_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        model_last_wr = win_wr;
        n_total++;
        if (rsp_valid_o !== 1'b0)
            $display("FAIL rsp_release: rsp_valid=%b required 0", rsp_valid_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #1;
        n_total++;
        if ({ar_ready_o, aw_ready_o, transaction_en_o, rsp_valid_o, rsp_allow_o, rsp_is_write_o,
             rsp_local_o, addr_o, total_length_o, num_bytes_o, sid_o} !== '0 || access_type_o !== ACCESS_NONE)
            $display("FAIL reset_state: en=%b rsp_v=%b addr=%h acc=%0d required all zero, acc=0",
                     transaction_en_o, rsp_valid_o, addr_o, access_type_o);
        else n_pass++;
        repeat (2) step();
        rst_ni = 1'b1;
        model_last_wr = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++)
            run_txn(1'b1, 1'b1, mk(64'h2000 + 64'(r) * 64'h100, 1, 2, 1, 8'h10),
                    mk(64'h8000 + 64'(r) * 64'h100, 0, 3, 0, 8'h20), r[0], 0, 0, 0, 1'b0);
    endtask

    task automatic test_single_read();
        run_txn(1'b1, 1'b0, mk(64'h1000, 3, 3, 1, 8'h5A), mk(64'h0, 0, 0, 0, 8'h0), 1'b1, 0, 0, 1, 1'b1);
    endtask

    task automatic test_wrap_and_local_deny();
        run_txn(1'b0, 1'b1, mk(64'h0, 0, 0, 0, 8'h0), mk(64'h103C, 3, 2, 2, 8'h33), 1'b0, 0, 0, 0, 1'b0);
        run_txn(1'b0, 1'b1, mk(64'h0, 0, 0, 0, 8'h0), mk(64'h4000, 0, 4, 1, 8'h34), 1'b1, 0, 0, 0, 1'b0);
        run_txn(1'b1, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFF0, 3, 3, 1, 8'h35), mk(64'h0, 0, 0, 0, 8'h0),
                1'b1, 0, 0, 0, 1'b0);
    endtask

    task automatic test_stall_issue();
        run_txn(1'b1, 1'b0, mk(64'h3000, 7, 3, 1, 8'h44), mk(64'h0, 0, 0, 0, 8'h0), 1'b1, 5, 0, 0, 1'b0);
    endtask

    task automatic test_rsp_backpressure();
        run_txn(1'b0, 1'b1, mk(64'h0, 0, 0, 0, 8'h0), mk(64'h5000, 1, 1, 1, 8'h55), 1'b1, 0, 4, 2, 1'b0);
    endtask

    task automatic test_reset_midop();
        ar_valid_i = 1'b1; ar_addr_i = 64'h7000; ar_len_i = 8'd1; ar_size_i = 3'd3;
        ar_burst_i = 2'd1; ar_sid_i = 8'h77;
        step();
        ar_valid_i = 1'b0;
        repeat (2) step();                       // now in WAIT with outputs loaded
        #2;
        rst_ni = 1'b0;
        #1;
        n_total++;
        if ({transaction_en_o, rsp_valid_o, addr_o, total_length_o, num_bytes_o, sid_o} !== '0 ||
            access_type_o !== ACCESS_NONE)
            $display("FAIL reset_midop: addr=%h len=%0d nb=%0d sid=%h acc=%0d required all zero",
                     addr_o, total_length_o, num_bytes_o, sid_o, access_type_o);
        else n_pass++;
        step();
        rst_ni = 1'b1;
        model_last_wr = 1'b1;
        step();
        run_txn(1'b1, 1'b1, mk(64'h9000, 0, 2, 0, 8'h78), mk(64'hA000, 0, 2, 0, 8'h79), 1'b1, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        int lens [7];
        tdesc_t ard, awd;
        bit arv, awv;
        lens = '{0, 1, 3, 7, 15, 5, 255};
        for (int n = 0; n < 40; n++) begin
            ard = mk({$urandom, $urandom}, lens[$urandom_range(0, 6)], $urandom_range(0, 4),
                     $urandom_range(0, 3), 8'($urandom));
            awd = mk({$urandom, $urandom}, lens[$urandom_range(0, 6)], $urandom_range(0, 4),
                     $urandom_range(0, 3), 8'($urandom));
            if ($urandom_range(0, 3) == 0) ard.addr = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 64));
            if ($urandom_range(0, 3) == 0) awd.addr = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 64));
            arv = 1'($urandom);
            awv = arv ? 1'($urandom) : 1'b1;
            run_txn(arv, awv, ard, awd, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        ar_valid_i = 1'b0; ar_addr_i = '0; ar_len_i = '0; ar_size_i = '0; ar_burst_i = '0; ar_sid_i = '0;
        aw_valid_i = 1'b0; aw_addr_i = '0; aw_len_i = '0; aw_size_i = '0; aw_burst_i = '0; aw_sid_i = '0;
        ml_ready_i = 1'b1; ml_valid_i = 1'b0; ml_allow_i = 1'b0; stall_i = 1'b0; rsp_ready_i = 1'b0;
        test_reset();
        test_back_to_back();
        test_single_read();
        test_wrap_and_local_deny();
        test_stall_issue();
        test_rsp_backpressure();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
